// File: rtl/key_event_scheduler.sv
// PS/2 scan-code front end for the pong game: tracks held paddle keys, paces paddle steps
// per frame slot, and queues control keys in a small FIFO for the game FSM.
module key_event_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int STEP_DIV   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       done,
  input  logic [7:0] tasta,
  input  logic       frame_tick,
  input  logic       step_enable,
  output logic       p1_step,
  output logic       p1_dir,
  output logic       p2_step,
  output logic       p2_dir,
  output logic [3:0] held,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready,
  output logic       overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [5:0] DIV_LAST = 6'(STEP_DIV - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_BRK = 2'd1, S_EXT = 2'd2, S_EXT_BRK = 2'd3;

  logic       done_q;
  logic [1:0] state;
  logic       cap, mk, bk;
  logic       pad_hit, ctl_hit;
  logic [1:0] pad_idx;
  logic [2:0] ctl_idx;
  logic [6:0] ctl_held;
  logic       push, flush, pop, full, do_push;
  logic [2:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [5:0] frame_cnt;
  logic       slot;
  logic [1:0] step_q, dir_q;

  assign cap = done & ~done_q;

  always_comb begin
    mk = cap && (state == S_IDLE) && (tasta != 8'hF0) && (tasta != 8'hE0);
    bk = cap && (state == S_BRK);
    pad_hit = 1'b0;
    pad_idx = 2'd0;
    ctl_hit = 1'b0;
    ctl_idx = 3'd0;
    case (tasta)
      8'h1C: begin pad_hit = 1'b1; pad_idx = 2'd0; end
      8'h23: begin pad_hit = 1'b1; pad_idx = 2'd1; end
      8'h3B: begin pad_hit = 1'b1; pad_idx = 2'd2; end
      8'h4B: begin pad_hit = 1'b1; pad_idx = 2'd3; end
      8'h29: begin ctl_hit = 1'b1; ctl_idx = 3'd0; end
      8'h76: begin ctl_hit = 1'b1; ctl_idx = 3'd1; end
      8'h16: begin ctl_hit = 1'b1; ctl_idx = 3'd2; end
      8'h1E: begin ctl_hit = 1'b1; ctl_idx = 3'd3; end
      8'h2D: begin ctl_hit = 1'b1; ctl_idx = 3'd4; end
      8'h34: begin ctl_hit = 1'b1; ctl_idx = 3'd5; end
      8'h32: begin ctl_hit = 1'b1; ctl_idx = 3'd6; end
      default: ;
    endcase
  end

  // done_q starts high so a byte already pending at reset release is ignored
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q   <= 1'b1;
      state    <= S_IDLE;
      held     <= 4'd0;
      ctl_held <= 7'd0;
    end else begin
      done_q <= done;
      if (cap) begin
        case (state)
          S_IDLE:  state <= (tasta == 8'hF0) ? S_BRK : (tasta == 8'hE0) ? S_EXT : S_IDLE;
          S_EXT:   state <= (tasta == 8'hF0) ? S_EXT_BRK : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
      if (mk && pad_hit) held[pad_idx] <= 1'b1;
      if (bk && pad_hit) held[pad_idx] <= 1'b0;
      if (mk && ctl_hit) ctl_held[ctl_idx] <= 1'b1;
      if (bk && ctl_hit) ctl_held[ctl_idx] <= 1'b0;
    end
  end

  assign push    = mk && ctl_hit && !ctl_held[ctl_idx];
  assign flush   = push && (ctl_idx == 3'd1);
  assign pop     = cmd_valid && cmd_ready;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_push = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (flush)        mem[0]      <= 3'd1;
    else if (do_push) mem[wr_ptr] <= ctl_idx;
  end

  // ESC discards everything queued and becomes the only entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(1);
      count  <= (AW+1)'(1);
    end else begin
      if (push && full && !pop) overflow <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
    end
  end

  assign cmd_valid = (count != '0);
  assign cmd_code  = cmd_valid ? mem[rd_ptr] : 3'd0;

  assign slot = frame_tick && step_enable && (frame_cnt == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= 6'd0;
      step_q    <= 2'd0;
      dir_q     <= 2'd0;
    end else begin
      if (!step_enable)    frame_cnt <= 6'd0;
      else if (frame_tick) frame_cnt <= (frame_cnt == DIV_LAST) ? 6'd0 : frame_cnt + 6'd1;
      for (int g = 0; g < 2; g++) begin
        step_q[g] <= slot && (held[2*g] ^ held[2*g+1]);
        if (slot && (held[2*g] ^ held[2*g+1])) dir_q[g] <= held[2*g+1];
      end
    end
  end

  assign p1_step = step_q[0];
  assign p2_step = step_q[1];
  assign p1_dir  = dir_q[0];
  assign p2_dir  = dir_q[1];
endmodule

// File: tb/tb_key_event_scheduler.sv
// Randomized bench for key_event_scheduler against a queue-based behavioural model.
module tb_key_event_scheduler;
  localparam int DEPTH = 4;
  localparam int DIV   = 3;

  logic       clock = 1'b0;
  logic       reset, done, frame_tick, step_enable, cmd_ready;
  logic [7:0] tasta;
  logic       p1_step, p1_dir, p2_step, p2_dir, cmd_valid, overflow;
  logic [3:0] held;
  logic [2:0] cmd_code;

  key_event_scheduler #(.FIFO_DEPTH(DEPTH), .STEP_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .done(done), .tasta(tasta),
    .frame_tick(frame_tick), .step_enable(step_enable),
    .p1_step(p1_step), .p1_dir(p1_dir), .p2_step(p2_step), .p2_dir(p2_dir),
    .held(held), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // behavioural model
  bit [3:0] m_held;
  bit [6:0] m_ctl;
  bit       m_brk, m_ext, m_ovf;
  int       m_q[$];
  int       m_cnt;
  bit [1:0] m_dir;

  function automatic int pad_of(input logic [7:0] b);
    case (b)
      8'h1C: return 0;
      8'h23: return 1;
      8'h3B: return 2;
      8'h4B: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int ctl_of(input logic [7:0] b);
    case (b)
      8'h29: return 0;
      8'h76: return 1;
      8'h16: return 2;
      8'h1E: return 3;
      8'h2D: return 4;
      8'h34: return 5;
      8'h32: return 6;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_held = '0; m_ctl = '0; m_brk = 0; m_ext = 0; m_ovf = 0;
    m_q.delete(); m_cnt = 0; m_dir = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit rdy);
    bit mk, bk, push, pop, was_full;
    int p, c;
    mk = 0; bk = 0; push = 0;
    pop = rdy && (m_q.size() > 0);
    if (m_ext) begin
      if (b == 8'hF0 && !m_brk) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      bk = 1; m_brk = 0;
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else mk = 1;
    p = pad_of(b);
    c = ctl_of(b);
    if (p >= 0 && mk) m_held[p] = 1;
    if (p >= 0 && bk) m_held[p] = 0;
    if (c >= 0) begin
      if (mk) begin push = !m_ctl[c]; m_ctl[c] = 1; end
      if (bk) m_ctl[c] = 0;
    end
    if (push && c == 1) begin
      m_q.delete();
      m_q.push_back(1);
    end else begin
      was_full = (m_q.size() == DEPTH);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (was_full && !pop) m_ovf = 1;
        else m_q.push_back(c);
      end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".held"}, held, m_held);
    chk({tag, ".valid"}, cmd_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk({tag, ".code"}, cmd_code, m_q[0]);
    chk({tag, ".ovf"}, overflow, m_ovf);
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    @(negedge clock);
    tasta = b; done = 1'b1; cmd_ready = rdy;
    @(negedge clock);
    done = 1'b0; cmd_ready = 1'b0;
    model_byte(b, rdy);
    check_state("byte");
  endtask

  task automatic tick(input bit en);
    bit slot;
    bit [1:0] exp_step;
    @(negedge clock);
    frame_tick = 1'b1; step_enable = en;
    exp_step = '0;
    if (en) begin
      slot = (m_cnt == DIV - 1);
      m_cnt = slot ? 0 : m_cnt + 1;
      if (slot)
        for (int g = 0; g < 2; g++)
          if (m_held[2*g] ^ m_held[2*g+1]) begin
            exp_step[g] = 1;
            m_dir[g] = m_held[2*g+1];
          end
    end else m_cnt = 0;
    @(negedge clock);
    frame_tick = 1'b0;
    chk("p1_step", p1_step, exp_step[0]);
    chk("p2_step", p2_step, exp_step[1]);
    chk("p1_dir", p1_dir, m_dir[0]);
    chk("p2_dir", p2_dir, m_dir[1]);
    @(negedge clock);
    chk("p1_step_end", p1_step, 0);
    chk("p2_step_end", p2_step, 0);
  endtask

  task automatic tick_slot();
    bit s;
    do begin
      s = (m_cnt == DIV - 1);
      tick(1'b1);
    end while (!s);
  endtask

  task automatic pop_one();
    @(negedge clock);
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
    check_state("pop");
  endtask

  task automatic drain();
    while (m_q.size() > 0) pop_one();
  endtask

  task automatic check_reset_outputs();
    chk("rst.p1_step", p1_step, 0);
    chk("rst.p2_step", p2_step, 0);
    chk("rst.p1_dir", p1_dir, 0);
    chk("rst.p2_dir", p2_dir, 0);
    chk("rst.held", held, 0);
    chk("rst.valid", cmd_valid, 0);
    chk("rst.code", cmd_code, 0);
    chk("rst.ovf", overflow, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; done = 1'b0; cmd_ready = 1'b0; frame_tick = 1'b0;
    model_reset();
    @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] pool [15] = '{8'h1C, 8'h23, 8'h3B, 8'h4B, 8'h29, 8'h76, 8'h16, 8'h1E,
                            8'h2D, 8'h34, 8'h32, 8'hF0, 8'hF0, 8'hE0, 8'h5A};

  initial begin
    reset = 1'b1; done = 1'b0; tasta = 8'h00; frame_tick = 1'b0;
    step_enable = 1'b0; cmd_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;

    // single paddle key, then release
    send(8'h1C, 0);
    tick_slot();
    send(8'hF0, 0); send(8'h1C, 0);
    tick_slot();

    // both directions held cancel out
    send(8'h23, 0); send(8'h1C, 0);
    tick_slot();
    send(8'hF0, 0); send(8'h1C, 0);
    tick_slot();
    send(8'hF0, 0); send(8'h23, 0);

    // typematic control key enqueues once
    repeat (3) send(8'h29, 0);
    send(8'hF0, 0); send(8'h29, 0); send(8'h29, 0);
    drain();
    send(8'hF0, 0); send(8'h29, 0);

    // fill, overflow, then ESC flush
    send(8'h29, 0); send(8'hF0, 0); send(8'h29, 0);
    send(8'h16, 0); send(8'hF0, 0); send(8'h16, 0);
    send(8'h1E, 0); send(8'hF0, 0); send(8'h1E, 0);
    send(8'h2D, 0); send(8'hF0, 0); send(8'h2D, 0);
    send(8'h34, 0);
    send(8'h76, 0);
    drain();

    // full FIFO with simultaneous pop and push
    do_reset();
    send(8'h29, 0); send(8'hF0, 0); send(8'h29, 0);
    send(8'h16, 0); send(8'hF0, 0); send(8'h16, 0);
    send(8'h1E, 0); send(8'hF0, 0); send(8'h1E, 0);
    send(8'h2D, 0); send(8'hF0, 0); send(8'h2D, 0);
    send(8'h34, 1);
    drain();

    // extended keys ignored; reset mid-break; byte pending across reset release
    send(8'hE0, 0); send(8'h1C, 0);
    tick_slot();
    send(8'hF0, 0);
    @(negedge clock);
    reset = 1'b1; tasta = 8'h23; done = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    done = 1'b0;
    @(negedge clock);
    check_state("pending");
    send(8'h1C, 0);
    tick_slot();

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) send(pool[$urandom_range(0, 14)], $urandom_range(0, 3) == 0);
      else if (r <= 7) tick($urandom_range(0, 4) != 0);
      else if (r == 8) pop_one();
      else tick_slot();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Sits between the PS/2 keyboard receiver and the pong game FSM.
- Decodes the raw scan-code stream (make, F0 break, E0 extended) into held-key state for the four paddle keys.
- Issues at most one paddle step per player per scheduled frame.
- Queues control keys (SPACE, ESC, 1, 2, R, G, B) in a small FIFO drained by the game FSM through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, number of control-command entries; power of two, 2..16.
- STEP_DIV, 1, frame ticks per paddle-step slot; 1..63.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- done  in  1  receiver byte-ready level; a rising edge marks a new byte on tasta.
- tasta  in  8  scan-code byte.
- frame_tick  in  1  one-cycle pulse per video frame.
- step_enable  in  1  1 = game running; 0 = paddle steps suppressed.
- p1_step  out  1  one-cycle pulse: move paddle 1.
- p1_dir  out  1  direction for p1_step: 1 = right (D, 8'h23), 0 = left (A, 8'h1C).
- p2_step  out  1  one-cycle pulse: move paddle 2.
- p2_dir  out  1  direction for p2_step: 1 = right (L, 8'h4B), 0 = left (J, 8'h3B).
- held  out  4  held-key state {p2R, p2L, p1R, p1L}.
- cmd_valid  out  1  FIFO head is valid.
- cmd_code  out  3  FIFO head: 0 SPACE 8'h29, 1 ESC 8'h76, 2 key1 8'h16, 3 key2 8'h1E, 4 R 8'h2D, 5 G 8'h34, 6 B 8'h32.
- cmd_ready  in  1  consumer accepts the head this cycle.
- overflow  out  1  sticky flag: a command was dropped.

Behaviour:
- Reset (asynchronous): all outputs 0; held = 0; FIFO empty; parser in IDLE; frame counter = 0; internal control-key held bits = 0.
- done_q resets to 1, so a done already high when reset releases is not consumed.
- Capture: a byte is taken on the cycle where done = 1 and done_q = 0. Parser state and held are updated on the next clock edge.
- Parser states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE + F0 -> BRK; IDLE + E0 -> EXT.
  - EXT + F0 -> EXT_BRK.
  - Any other byte applies as a make in IDLE, or as a break in BRK, then returns to IDLE.
  - Bytes received in EXT or EXT_BRK are discarded, then the parser returns to IDLE. Extended keys are never mapped.
  - Unmapped codes: no effect beyond the state return.
- Paddle keys: a make sets the matching held bit; a break clears it. A repeated make (typematic) is idempotent.
- Control keys:
  - A make enqueues the command only if that key's internal held bit is 0; the bit is then set. Typematic repeats therefore do not re-enqueue.
  - A break clears the internal held bit and does not enqueue.
- ESC make: flushes the FIFO and writes ESC as the sole entry in the same cycle. This never sets overflow.
- FIFO:
  - cmd_valid = not empty; cmd_code = head.
  - Pop when cmd_valid && cmd_ready.
  - Write-to-read latency is 1 cycle: cmd_valid rises the cycle after the parser update.
  - Push and pop in the same cycle while full: both succeed, and the count is unchanged.
  - Push while full without pop: the new entry is dropped, overflow is set to 1, and it stays set until reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Step scheduler:
  - frame_cnt (6-bit) advances on each frame_tick while step_enable = 1, and wraps to 0 at STEP_DIV-1. A slot is a frame_tick arriving when frame_cnt = STEP_DIV-1.
  - When step_enable = 0, frame_cnt is forced to 0 and no steps are issued.
  - In a slot, for each player independently: exactly one direction held -> pN_step pulses 1 cycle, registered the cycle after frame_tick, with pN_dir set to that direction. Both held or neither held -> no pulse.
  - pN_dir holds its last value between pulses.
  - held is sampled as registered in the frame_tick cycle. A byte that updates held in that same cycle takes effect in the next slot.
- Reset mid-byte or mid-sequence (for example after F0): the parser returns to IDLE, and the next byte is treated as a make.

Test Plan:
- Send 1C, then frame_tick with step_enable = 1 and STEP_DIV = 1 -> held = 4'b0001; p1_step pulses once 1 cycle after the tick with p1_dir = 0. Then send F0 1C -> held = 0; next tick gives no pulse.
- Send 23 and 1C (both held), then tick -> no p1_step. Send F0 1C, then tick -> p1_step with p1_dir = 1.
- Send 29 three times (typematic) with cmd_ready = 0 -> exactly one entry, code 0. Send F0 29 29 -> second entry, code 0.
- Fill 4 entries (29, 16, 1E, 2D, with breaks between), then send 34 -> dropped and overflow = 1. Then send 76 -> FIFO holds only code 1; overflow stays 1.
- Full FIFO with cmd_ready = 1 while a new make lands -> count stays 4, no overflow, head advances in order.
- Send E0 1C, then tick -> held = 0, no step. Reset after F0, then send 1C -> held = 4'b0001.
